// File: rtl/izhikevich_update_unit.sv
// Izhikevich neuron update sequencer: sweeps every neuron once, reads v/u from the
// state register, computes the Q8.8 update with the sampled current and writes it back.
module izhikevich_update_unit #(
  parameter int                       numwidth   = 16,
  parameter int                       numneurons = 2,
  parameter int                       tagbits    = 1,
  parameter logic signed [numwidth:0] pa         = 17'sd5,
  parameter logic signed [numwidth:0] pb         = 17'sd51,
  parameter logic signed [numwidth:0] pc         = -17'sd16640,
  parameter logic signed [numwidth:0] pd         = 17'sd2048,
  parameter logic signed [numwidth:0] vthresh    = 17'sd7680
) (
  input  logic                       clk,
  input  logic                       asyn_reset,
  input  logic                       start,
  input  logic signed [numwidth:0]   v,
  input  logic signed [numwidth:0]   u,
  input  logic signed [numwidth:0]   i_in,
  output logic                       read,
  output logic                       write,
  output logic        [tagbits-1:0]  tag,
  output logic signed [numwidth:0]   v_new,
  output logic signed [numwidth:0]   u_new,
  output logic                       spike,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = 40;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic signed [numwidth:0] word_t;

  localparam acc_t SAT_MAX = {{(AW - numwidth){1'b0}}, {numwidth{1'b1}}};
  localparam acc_t SAT_MIN = {{(AW - numwidth){1'b1}}, {numwidth{1'b0}}};
  localparam logic [tagbits-1:0] LAST_TAG = tagbits'(numneurons - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    CALC,
    WRITE,
    DONE
  } state_t;

  state_t             state_q;
  logic [tagbits-1:0] tag_q;
  logic               read_q, write_q, spike_q, busy_q, done_q;
  word_t              v_new_q, u_new_q;
  word_t              v_q, u_q, i_q;

  acc_t  v_w, u_w, i_w, vsq, vn, bv, un;
  logic  fire_d;
  word_t v_new_d, u_new_d;

  function automatic word_t sat(input acc_t x);
    if (x > SAT_MAX) return SAT_MAX[numwidth:0];
    if (x < SAT_MIN) return SAT_MIN[numwidth:0];
    return x[numwidth:0];
  endfunction

  // Full-precision update; every >>> 8 floors, and saturation touches only the final values.
  always_comb begin
    v_w     = acc_t'(v_q);
    u_w     = acc_t'(u_q);
    i_w     = acc_t'(i_q);
    vsq     = (((v_w * v_w) >>> 8) * acc_t'(10)) >>> 8;
    vn      = v_w + vsq + acc_t'(5) * v_w + acc_t'(35840) - u_w + i_w;
    bv      = (acc_t'(pb) * v_w) >>> 8;
    un      = u_w + ((acc_t'(pa) * (bv - u_w)) >>> 8);
    fire_d  = (vn >= acc_t'(vthresh));
    v_new_d = fire_d ? pc : sat(vn);
    u_new_d = fire_d ? sat(un + acc_t'(pd)) : sat(un);
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      spike_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v_new_q <= '0;
      u_new_q <= '0;
      // NOTE: operand registers are cleared too so no X can reach v_new/u_new after reset.
      v_q     <= '0;
      u_q     <= '0;
      i_q     <= '0;
    end else begin
      // NOTE: strobes default low each cycle; the later assignments in the case win (non-blocking).
      read_q  <= 1'b0;
      write_q <= 1'b0;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            tag_q   <= '0;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: state_q <= LOAD;
        LOAD: begin
          v_q     <= v;
          u_q     <= u;
          i_q     <= i_in;
          state_q <= CALC;
        end
        CALC: begin
          v_new_q <= v_new_d;
          u_new_q <= u_new_d;
          spike_q <= fire_d;
          write_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          if (tag_q == LAST_TAG) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            tag_q   <= tag_q + 1'b1;
            read_q  <= 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read  = read_q;
  assign write = write_q;
  assign tag   = tag_q;
  assign v_new = v_new_q;
  assign u_new = u_new_q;
  assign spike = spike_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_izhikevich_update_unit.sv
// Directed bench for izhikevich_update_unit: drives per-neuron state and current,
// queues hand-computed write-backs and checks sweep timing cycle by cycle.
module tb_izhikevich_update_unit;

  typedef logic signed [16:0] word_t;
  typedef struct packed {
    logic  tag;
    word_t v_new;
    word_t u_new;
    logic  spike;
  } wb_t;

  logic       clk = 1'b0;
  logic       asyn_reset, start;
  word_t      v, u, i_in;
  logic       read, write, spike, busy, done;
  logic [0:0] tag;
  word_t      v_new, u_new;

  int    n_cmp = 0;
  int    n_bad = 0;
  wb_t   sb_q[$];
  word_t sv[2], su[2], si[2];
  word_t last_v = '0;
  word_t last_u = '0;

  izhikevich_update_unit dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .start      (start),
    .v          (v),
    .u          (u),
    .i_in       (i_in),
    .read       (read),
    .write      (write),
    .tag        (tag),
    .v_new      (v_new),
    .u_new      (u_new),
    .spike      (spike),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic load_neuron(input int idx, input int vi, input int ui, input int ii,
                             input int ev, input int eu, input bit es);
    wb_t e;
    sv[idx] = word_t'(vi);
    su[idx] = word_t'(ui);
    si[idx] = word_t'(ii);
    e.tag   = 1'(idx);
    e.v_new = word_t'(ev);
    e.u_new = word_t'(eu);
    e.spike = es;
    sb_q.push_back(e);
  endtask

  // cyc counts from 1 = first cycle after the edge that sampled start.
  task automatic observe(input int cyc);
    logic        exp_rd, exp_wr, exp_dn, exp_bs;
    logic [35:0] got, exp;
    wb_t         e;
    exp_rd = (cyc == 1) || (cyc == 5);
    exp_wr = (cyc == 4) || (cyc == 8);
    exp_dn = (cyc == 9);
    exp_bs = (cyc <= 9);
    check($sformatf("ctl_c%0d", cyc), 64'({read, write, done, busy}),
          64'({exp_rd, exp_wr, exp_dn, exp_bs}));
    if (exp_wr) begin
      got = {tag[0], v_new, u_new, spike};
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_underflow_c%0d: observed empty queue expected pending write-back", cyc);
      end
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        exp = e;
        check($sformatf("wb_c%0d", cyc), 64'(got), 64'(exp));
        last_v = e.v_new;
        last_u = e.u_new;
      end
    end else begin
      check($sformatf("hold_c%0d", cyc), 64'({v_new, u_new, spike}), 64'({last_v, last_u, 1'b0}));
    end
  endtask

  // Start is sampled at the next edge; a stray start in CALC and a start held
  // through DONE must both be ignored.
  task automatic run_sweep(input int ncyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      v    = sv[tag];
      u    = su[tag];
      i_in = si[tag];
      if (cyc == 3 || cyc == 9) start = 1'b1;
      if (cyc == 4 || cyc == 10) start = 1'b0;
      observe(cyc);
    end
  endtask

  initial begin
    asyn_reset = 1'b1;
    start      = 1'b0;
    v          = '0;
    u          = '0;
    i_in       = '0;
    #12;
    check("reset_outputs", 64'({read, write, tag, v_new, u_new, spike, busy, done}), 64'(0));
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 64'({busy, read, write, done}), 64'(0));

    // Resting neuron and a neuron at 0 that fires.
    load_neuron(0, -16640, -3328, 0, -18422, -3328, 1'b0);
    load_neuron(1, 0, 0, 0, -16640, 2048, 1'b1);
    run_sweep(12);

    // Negative v saturation, and a firing neuron whose u+d saturates high.
    load_neuron(0, 0, 65280, -65536, -65536, 64005, 1'b0);
    load_neuron(1, 0, 65000, 36840, -16640, 65535, 1'b1);
    run_sweep(12);

    // Reset lands mid-cycle 6: tag 0 already written, tag 1 abandoned.
    load_neuron(0, 0, 0, -28161, 7679, 0, 1'b0);
    load_neuron(1, 0, 0, 0, -16640, 2048, 1'b1);
    run_sweep(6);
    #2 asyn_reset = 1'b1;
    #1;
    check("reset_mid_sweep", 64'({read, write, tag, v_new, u_new, spike, busy, done}), 64'(0));
    @(posedge clk); #1;
    check("held_in_reset", 64'({read, write, busy, done, v_new, u_new}), 64'(0));
    asyn_reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_release", 64'({busy, read, write}), 64'(0));
    sb_q.delete();
    last_v = '0;
    last_u = '0;

    // Fresh sweep from tag 0: threshold reached exactly, and a floor-sensitive u update.
    load_neuron(0, 0, 0, -28160, -16640, 2048, 1'b1);
    load_neuron(1, -16640, 0, 0, -21750, -65, 1'b0);
    run_sweep(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/izhikevich_update_unit.md
# izhikevich_update_unit

Sweeps every neuron once per simulation timestep. For each neuron it reads the v and u state from the state register, applies the Izhikevich update with a synaptic current sampled for that neuron, and writes the new v and u back. It flags a spike when the neuron fires. It sits directly upstream of the state register, driving its read, write, tag and v_new/u_new ports and consuming its registered v/u outputs.

## Interface
- numwidth, 16: MSB index of state words; words are numwidth+1 = 17 bits, signed Q8.8 (1 sign, 8 int, 8 frac).
- numneurons, 2: neurons per sweep; power of two.
- tagbits, 1: log2(numneurons).
- pa, 17'sd5: a ≈ 0.02, Q8.8.
- pb, 17'sd51: b ≈ 0.2, Q8.8.
- pc, -17'sd16640: reset potential c = -65.0.
- pd, 17'sd2048: recovery increment d = 8.0.
- vthresh, 17'sd7680: spike threshold 30.0.
- clk  in  1  clock; all state changes on posedge.
- asyn_reset  in  1  reset, asynchronous and active-high.
- start  in  1  begin one sweep; sampled only in IDLE.
- v, u  in  numwidth+1  state-register outputs, valid the cycle after read.
- i_in  in  numwidth+1  synaptic current for the current tag, Q8.8.
- read  out  1  state-register read strobe.
- write  out  1  state-register write strobe.
- tag  out  tagbits  neuron being processed.
- v_new, u_new  out  numwidth+1  write-back values.
- spike  out  1  one-cycle pulse in the WRITE cycle of a firing neuron; tag identifies it.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last write-back.

## Operation
- FSM states: IDLE, READ, LOAD, CALC, WRITE, DONE.
- IDLE to READ on start. Clear tag to 0.
- READ: read=1. Go to LOAD.
- LOAD: capture v, u and i_in into internal registers. Go to CALC.
- CALC: register the products and sums. Go to WRITE.
- WRITE: write=1 and drive v_new/u_new. Assert spike if the neuron fired. If tag = numneurons-1, go to DONE; otherwise increment tag and go to READ.
- DONE: done=1. Go to IDLE.
- read and write are never high in the same cycle. In every non-strobe state, read=0 and write=0.
- Arithmetic: full precision in ≥40-bit signed. Every ">>>8" is an arithmetic shift, i.e. floor.
  - vsq = ((v*v)>>>8 * 10)>>>8, where 10 ≈ 0.04.
  - vn = v + vsq + 5v + 35840 - u + i_in.
  - un = u + (pa*(((pb*v)>>>8) - u))>>>8.
- Firing: compare vn before saturation. If vn ≥ vthresh, the neuron fires: spike=1, v_new=pc, u_new=sat(un+pd).
- No firing: v_new=sat(vn), u_new=sat(un).
- sat clamps to [-65536, 65535]. It is applied only to the final values.
- start is ignored while busy. start held high in DONE does not retrigger until IDLE is reached.
- Reset mid-sweep: return to IDLE immediately. The partial sweep is abandoned. Neurons already written keep their new values; the remaining neurons keep their old values.

## Timing
- Reset values: read=0, write=0, tag=0, v_new=0, u_new=0, spike=0, busy=0, done=0. FSM in IDLE.
- Each neuron takes 4 cycles (READ, LOAD, CALC, WRITE).
- Sweep latency: if start is sampled at edge 0, READ for tag 0 occupies cycle 1 and WRITE for tag t occupies cycle 4t+4. done is high in cycle 4·numneurons+1, and busy falls at the following edge.
- v_new and u_new are registered and remain stable outside WRITE. spike and done are single-cycle pulses.

## Test plan
- Reset: assert asyn_reset mid-cycle -> all outputs 0 immediately, FSM in IDLE; start after release begins a normal sweep.
- Resting neuron: v=-16640, u=-3328, i_in=0 -> WRITE with v_new=-18422, u_new=-3328, spike=0.
- Firing: v=0, u=0, i_in=0 -> vn=35840 ≥ 7680, so spike=1, v_new=-16640, u_new=2048.
- Negative saturation: v=0, u=65280, i_in=-65536 -> v_new=-65536, u_new=64005, spike=0.
- Two-neuron sweep: start at edge 0 -> read at cycles 1 and 5 (tags 0, 1), write at cycles 4 and 8, done at cycle 9; start pulsed at cycle 3 is ignored; no cycle has read and write both high.
- Reset at cycle 6 of the sweep: tag 0 has been written, tag 1 has not; busy drops, and a new start repeats the full sweep from tag 0.
